// File: rtl/mem_stream_pkg.sv
// Shared constants and types for the memory stream reader.
// Imported by the interface, FIFO and top level.
package mem_stream_pkg;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Control, memory-port and stream bundle of the reader.
// master = reader side, slave = surrounding logic.
interface mem_stream_reader_if
  import mem_stream_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);

  logic          start;
  logic          abort;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    input  start, abort, base, count,
    input  mem_data, m_ready,
    output busy, done, mem_we, mem_addr,
    output m_valid, m_data, m_last
  );

  modport slave (
    output start, abort, base, count,
    output mem_data, m_ready,
    input  busy, done, mem_we, mem_addr,
    input  m_valid, m_data, m_last
  );

endinterface

// File: rtl/mem_stream_fifo2.sv
// Two-entry FIFO buffering read data ahead of the stream port.
// Flush wins over push and pop in the same cycle.
module mem_stream_fifo2
  import mem_stream_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [1:0]    count,
  output logic [DW-1:0] head
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic [DW-1:0] slot [FIFO_DEPTH];
  logic          rptr;
  logic          wptr;
  logic [1:0]    cnt;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != FULL) || do_pop);
  assign count   = cnt;
  assign head    = slot[rptr];

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= 1'b0;
      wptr <= 1'b0;
      cnt  <= 2'd0;
    end else if (flush) begin
      rptr <= 1'b0;
      wptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (do_push) wptr <= ~wptr;
      if (do_pop)  rptr <= ~rptr;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // data storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !flush) slot[wptr] <= din;
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Sequencer reading a run of words from a sync-read memory
// and streaming them out with full valid/ready backpressure.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_stream_reader_if.master bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [ADDR_WIDTH:0] DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_C =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A =
    ADDR_WIDTH'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   rem_issue;
  logic [ADDR_WIDTH:0]   rem_out;
  logic [ADDR_WIDTH:0]   cnt_sat;
  logic                  rd_pend;
  logic [1:0]            fcount;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            occ;
  logic                  pop;
  logic                  issue;
  logic                  flush;

  assign cnt_sat = (bus.count > DEPTH) ? DEPTH : bus.count;
  assign pop     = bus.m_valid && bus.m_ready;
  assign occ     = {1'b0, fcount} + {2'b0, rd_pend};
  assign flush   = bus.abort && (state != S_IDLE);
  // keep in-flight read plus buffered words within two slots
  assign issue   = (state == S_RUN) &&
                   (rem_issue != '0) &&
                   ((occ - {2'b0, pop}) < 3'd2);

  assign bus.mem_we   = 1'b0;
  assign bus.mem_addr = addr;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.m_valid  = (fcount != 2'd0);
  assign bus.m_data   = head;
  assign bus.m_last   = bus.m_valid && (rem_out == ONE_C);

  mem_stream_fifo2 #(.DW(DATA_WIDTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (rd_pend),
    .pop   (pop),
    .flush (flush),
    .din   (bus.mem_data),
    .count (fcount),
    .head  (head)
  );

  // run FSM, address and counters, read-pending flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      addr      <= '0;
      rem_issue <= '0;
      rem_out   <= '0;
      rd_pend   <= 1'b0;
    end else if (flush) begin
      state   <= S_IDLE;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (pop) rem_out <= rem_out - ONE_C;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            addr      <= bus.base;
            rem_issue <= cnt_sat;
            rem_out   <= cnt_sat;
            state     <= (cnt_sat == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            addr      <= addr + ONE_A;
            rem_issue <= rem_issue - ONE_C;
            if (rem_issue == ONE_C) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && (rem_out == ONE_C)) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized self-checking bench for mem_stream_reader.
// Expected streams come from the memory array and run rules.
module tb_mem_stream_reader;
  import mem_stream_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stream_reader_if bus ();

  mem_stream_reader dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] mem [64];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  int n_chk  = 0;
  int n_fail = 0;
  int pat [6] = '{1, 0, 0, 1, 0, 1};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic pick_ready(input int mode, input int k,
                            output logic r);
    case (mode)
      0:       r = 1'b1;
      1:       r = pat[k % 6] != 0;
      default: r = 1'($urandom_range(0, 1));
    endcase
  endtask

  // mode 0: ready always high, so exact latency is checked
  task automatic do_run(input logic [5:0] b,
                        input logic [6:0] c,
                        input int mode);
    logic [31:0] q [$];
    logic [31:0] held;
    logic [5:0]  issued;
    logic [5:0]  a;
    logic        r;
    int n, e, first_v, done_e, consumed;
    bit stall;
    n = (c > 7'd64) ? 64 : int'(c);
    for (int i = 0; i < n; i++) begin
      a = b + 6'(i);
      q.push_back(mem[a]);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = b;
    bus.count = c;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_start", 32'(bus.busy), 1);
    chk("we_low", 32'(bus.mem_we), 0);
    e = 0; first_v = -1; done_e = -1;
    stall = 1'b0; consumed = 0; held = '0;
    while (done_e < 0 && e < 1000) begin
      pick_ready(mode, e, r);
      bus.m_ready = r;
      if (stall) begin
        chk("stall_valid", 32'(bus.m_valid), 1);
        chk("stall_data", bus.m_data, held);
      end
      if (bus.m_valid && first_v < 0) first_v = e;
      if (n < 64 && bus.busy) begin
        issued = bus.mem_addr - b;
        chk("ahead",
            32'((int'(issued) - consumed) <= 2), 1);
      end
      if (bus.m_valid && r) begin
        if (q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          chk("data", bus.m_data, q[0]);
          chk("last", 32'(bus.m_last), 32'(q.size() == 1));
          void'(q.pop_front());
        end
        consumed++;
      end
      stall = bus.m_valid && !r;
      held  = bus.m_data;
      if (bus.done) done_e = e;
      if (done_e < 0) begin
        @(negedge clk);
        e++;
      end
    end
    chk("done_seen", 32'(done_e >= 0), 1);
    chk("words_left", 32'(q.size()), 0);
    if (n == 0) chk("cnt0_valid", 32'(first_v), 32'(-1));
    if (mode == 0) begin
      chk("first_valid", 32'(first_v), n == 0 ? 32'(-1) : 2);
      // done high in the cycle closed by edge n+3
      chk("done_lat", 32'(done_e), n == 0 ? 0 : 32'(n + 2));
    end
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 0);
    chk("idle", 32'(bus.busy), 0);
    bus.m_ready = 1'b0;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.base    = '0;
    bus.count   = '0;
    bus.m_ready = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = 32'(k * 3);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_valid", 32'(bus.m_valid), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    rst = 1'b0;

    do_run(6'd0, 7'd4, 0);
    do_run(6'd62, 7'd4, 0);
    do_run(6'd0, 7'd6, 1);
    do_run(6'd10, 7'd0, 0);
    do_run(6'd5, 7'd100, 0);

    @(negedge clk);
    bus.start   = 1'b1;
    bus.base    = 6'd30;
    bus.count   = 7'd10;
    bus.m_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_pre_valid", 32'(bus.m_valid), 1);
    bus.abort   = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.abort   = 1'b0;
    bus.m_ready = 1'b0;
    chk("abort_valid", 32'(bus.m_valid), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 0);
    end
    do_run(6'd20, 7'd5, 0);

    @(negedge clk);
    bus.start   = 1'b1;
    bus.base    = 6'd0;
    bus.count   = 7'd20;
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_valid", 32'(bus.m_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.m_valid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.m_ready = 1'b0;
    do_run(6'd0, 7'd4, 0);

    repeat (10) begin
      for (int k = 0; k < 64; k++) mem[k] = $urandom;
      do_run(6'($urandom), 7'($urandom_range(0, 90)),
             int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
